// File: rtl/register_bank.sv
// register_bank: general-purpose register file with two combinational read
// ports and one synchronous write port. A write presented in the current
// cycle is forwarded to any read port addressing the same register, so a
// write-back value is visible to a decode-stage read in that same cycle.
module register_bank #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_HARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_r1,
    input  logic [ADDR_W-1:0] i_r2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              regwrite,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_en;
    logic              r1_zero;
    logic              r2_zero;

    // An effective write: enabled, and not aimed at a hardwired-zero register 0.
    assign wr_en   = regwrite && !((ZERO_HARD != 0) && (write_register == '0));
    assign r1_zero = (ZERO_HARD != 0) && (i_r1 == '0);
    assign r2_zero = (ZERO_HARD != 0) && (i_r2 == '0);

    // Storage update: synchronous clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is cleared here because software relies on
            // every register reading zero after reset; that makes this a flop
            // array rather than a RAM macro, which is acceptable at 32 entries.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every reader of regs_q in this edge sees
            // the pre-edge contents, independent of block evaluation order.
            regs_q[write_register] <= write_data;
        end
    end

    // Read ports: zero register, then same-cycle write bypass, then storage.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch
        // is inferred.
        d1 = regs_q[i_r1];
        d2 = regs_q[i_r2];
        if (r1_zero) begin
            d1 = '0;
        end else if (wr_en && (i_r1 == write_register)) begin
            d1 = write_data;
        end
        if (r2_zero) begin
            d2 = '0;
        end else if (wr_en && (i_r2 == write_register)) begin
            d2 = write_data;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed literal checks plus randomized traffic, with a
// per-cycle comparison of both read ports against a behavioural model.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  i_r1;
    logic [4:0]  i_r2;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        regwrite;
    logic [31:0] d1;
    logic [31:0] d2;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: plain array of register contents.
    logic [31:0] mdl [32];
    bit          mdl_valid = 1'b0;

    always #5 clk = ~clk;

    register_bank #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_HARD(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_r1          (i_r1),
        .i_r2          (i_r2),
        .write_register(write_register),
        .write_data    (write_data),
        .regwrite      (regwrite),
        .d1            (d1),
        .d2            (d2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of address a must return right now, from the rules:
    // r0 is zero; a pending write to the same address is forwarded;
    // otherwise the stored value.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (regwrite && (a == write_register)) return write_data;
        return mdl[a];
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] <= 32'd0;
            mdl_valid <= 1'b1;
        end else if (regwrite && (write_register != 5'd0)) begin
            mdl[write_register] <= write_data;
        end
    end

    // Compare process: both ports against the model, mid-cycle.
    always @(negedge clk) begin
        if (mdl_valid) begin
            check("d1_model", d1, expect_rd(i_r1));
            check("d2_model", d2, expect_rd(i_r2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
        write_register = a;
        write_data     = v;
        regwrite       = 1'b1;
        tick();
        regwrite       = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        i_r1           = '0;
        i_r2           = '0;
        write_register = '0;
        write_data     = '0;
        regwrite       = 1'b0;
        tick();
        reset = 1'b0;

        // Reset sweep: every address reads zero on both ports.
        for (int a = 0; a < 32; a++) begin
            i_r1 = 5'(a);
            i_r2 = 5'(31 - a);
            #1;
            check("reset_sweep_d1", d1, 32'd0);
            check("reset_sweep_d2", d2, 32'd0);
        end

        // Write / read back, then a disabled write must not change r1.
        write_reg(5'd1, 32'd555);
        write_reg(5'd2, 32'd222);
        i_r1 = 5'd1;
        i_r2 = 5'd2;
        #2;
        check("wr_r1", d1, 32'd555);
        check("wr_r2", d2, 32'd222);
        write_register = 5'd1;
        write_data     = 32'd7;
        regwrite       = 1'b0;
        tick();
        #2;
        check("nowrite_r1", d1, 32'd555);

        // Register 0 ignores writes and is never bypassed.
        i_r1           = 5'd0;
        write_register = 5'd0;
        write_data     = 32'd555;
        regwrite       = 1'b1;
        #2;
        check("r0_no_bypass", d1, 32'd0);
        tick();
        regwrite = 1'b0;
        #2;
        check("r0_after_write", d1, 32'd0);

        // Bypass: value visible before the edge and retained after it.
        i_r1           = 5'd5;
        write_register = 5'd5;
        write_data     = 32'hDEADBEEF;
        regwrite       = 1'b1;
        #2;
        check("bypass_before", d1, 32'hDEADBEEF);
        tick();
        regwrite   = 1'b0;
        write_data = 32'd0;
        #2;
        check("bypass_after", d1, 32'hDEADBEEF);

        // Dual read of the same register, stored and bypassed.
        write_reg(5'd31, 32'h1234);
        i_r1 = 5'd31;
        i_r2 = 5'd31;
        #2;
        check("dual_d1", d1, 32'h1234);
        check("dual_d2", d2, 32'h1234);
        i_r1           = 5'd7;
        i_r2           = 5'd7;
        write_register = 5'd7;
        write_data     = 32'hCAFE_F00D;
        regwrite       = 1'b1;
        #2;
        check("dual_bypass_d1", d1, 32'hCAFE_F00D);
        check("dual_bypass_d2", d2, 32'hCAFE_F00D);
        tick();
        regwrite = 1'b0;

        // Reset together with a write: reset wins, earlier contents cleared.
        reset          = 1'b1;
        write_register = 5'd3;
        write_data     = 32'd9;
        regwrite       = 1'b1;
        tick();
        reset    = 1'b0;
        regwrite = 1'b0;
        i_r1     = 5'd3;
        i_r2     = 5'd1;
        #2;
        check("rst_wr_r3", d1, 32'd0);
        check("rst_wr_r1", d2, 32'd0);
        i_r1 = 5'd31;
        i_r2 = 5'd7;
        #1;
        check("rst_wr_r31", d1, 32'd0);
        check("rst_wr_r7", d2, 32'd0);

        // Randomized traffic, biased toward read/write address collisions.
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset          = ($urandom_range(0, 63) == 0);
            regwrite       = 1'($urandom_range(0, 1));
            write_register = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            write_data     = $urandom;
            i_r1           = ($urandom_range(0, 3) == 0) ? write_register : 5'($urandom);
            i_r2           = ($urandom_range(0, 3) == 0) ? i_r1 : 5'($urandom);
        end
        tick();
        reset    = 1'b0;
        regwrite = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
